// File: rtl/issue_pair_router.sv
// Issue-pair router: steers a fetched instruction pair into the even/odd
// issue slots of the dual-issue execution block. Pairs that cannot go out
// together (both on the same pipe, or the second reads what the first writes)
// are split over two cycles, with the second instruction parked in hold
// registers. Honours the execution block's RAW stall and branch flush.
module issue_pair_router #(
    parameter logic [0:31] NOP_EVEN = 32'h40200000,
    parameter logic [0:31] NOP_ODD  = 32'h00200000,
    parameter int          PC_W     = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_valid,
    output logic            fetch_ready,
    input  logic [0:31]     instr_a,
    input  logic [0:31]     instr_b,
    input  logic [PC_W-1:0] pc_a,
    input  logic            odd_a,
    input  logic            odd_b,
    input  logic            wr_a,
    input  logic [0:6]      rt_a,
    input  logic [0:6]      ra_b,
    input  logic [0:6]      rb_b,
    input  logic [0:6]      rc_b,
    input  logic [2:0]      src_b_used,
    input  logic            stall_even_raw,
    input  logic            stall_odd_raw,
    input  logic            branch_taken,
    output logic [0:31]     instr_even,
    output logic [0:31]     instr_odd,
    output logic [PC_W-1:0] pc,
    output logic            first_odd,
    output logic            issue_valid
);

    typedef enum logic {RUN, SECOND} state_t;

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    state_t          state_reg, state_next;
    logic [0:31]     instr_even_reg, instr_even_next;
    logic [0:31]     instr_odd_reg, instr_odd_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic            first_odd_reg, first_odd_next;
    logic            issue_valid_reg, issue_valid_next;
    logic [0:31]     hold_instr_reg, hold_instr_next;
    logic            hold_odd_reg, hold_odd_next;
    logic [PC_W-1:0] hold_pc_reg, hold_pc_next;

    logic            stall;
    logic            dep;
    logic            pairable;
    logic            accept;

    // Source operands of instr_b, indexed to line up with src_b_used bits.
    logic [0:6]      src_addr [3];
    logic [2:0]      src_hit;

    assign src_addr[2] = ra_b;
    assign src_addr[1] = rb_b;
    assign src_addr[0] = rc_b;

    // A source only counts as a hazard when it is actually read.
    for (genvar gi = 0; gi < 3; gi++) begin : g_src_hit
        assign src_hit[gi] = src_b_used[gi] && (src_addr[gi] == rt_a);
    end

    assign stall       = stall_even_raw | stall_odd_raw;
    assign dep         = wr_a && (|src_hit);
    assign pairable    = (odd_a != odd_b) && !dep;
    assign fetch_ready = !reset && (state_reg == RUN) && !stall && !branch_taken;
    assign accept      = fetch_valid && fetch_ready;

    // Next-state and slot steering; flush beats stall, stall freezes everything.
    always_comb begin
        state_next       = state_reg;
        instr_even_next  = instr_even_reg;
        instr_odd_next   = instr_odd_reg;
        pc_next          = pc_reg;
        first_odd_next   = first_odd_reg;
        issue_valid_next = issue_valid_reg;
        hold_instr_next  = hold_instr_reg;
        hold_odd_next    = hold_odd_reg;
        hold_pc_next     = hold_pc_reg;

        if (branch_taken) begin
            instr_even_next  = NOP_EVEN;
            instr_odd_next   = NOP_ODD;
            issue_valid_next = 1'b0;
            hold_instr_next  = '0;
            hold_odd_next    = 1'b0;
            hold_pc_next     = '0;
            state_next       = RUN;
        end else if (!stall) begin
            case (state_reg)
                RUN: begin
                    if (accept) begin
                        pc_next          = pc_a;
                        first_odd_next   = odd_a;
                        issue_valid_next = 1'b1;
                        if (pairable) begin
                            instr_even_next = odd_a ? instr_b : instr_a;
                            instr_odd_next  = odd_a ? instr_a : instr_b;
                        end else begin
                            instr_even_next = odd_a ? NOP_EVEN : instr_a;
                            instr_odd_next  = odd_a ? instr_a : NOP_ODD;
                            hold_instr_next = instr_b;
                            hold_odd_next   = odd_b;
                            hold_pc_next    = pc_a + PC_ONE;
                            state_next      = SECOND;
                        end
                    end else begin
                        instr_even_next  = NOP_EVEN;
                        instr_odd_next   = NOP_ODD;
                        issue_valid_next = 1'b0;
                    end
                end
                SECOND: begin
                    instr_even_next  = hold_odd_reg ? NOP_EVEN : hold_instr_reg;
                    instr_odd_next   = hold_odd_reg ? hold_instr_reg : NOP_ODD;
                    pc_next          = hold_pc_reg;
                    first_odd_next   = hold_odd_reg;
                    issue_valid_next = 1'b1;
                    state_next       = RUN;
                end
                default: state_next = RUN;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= RUN;
            instr_even_reg  <= NOP_EVEN;
            instr_odd_reg   <= NOP_ODD;
            pc_reg          <= '0;
            first_odd_reg   <= 1'b0;
            issue_valid_reg <= 1'b0;
            hold_instr_reg  <= '0;
            hold_odd_reg    <= 1'b0;
            hold_pc_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            instr_even_reg  <= instr_even_next;
            instr_odd_reg   <= instr_odd_next;
            pc_reg          <= pc_next;
            first_odd_reg   <= first_odd_next;
            issue_valid_reg <= issue_valid_next;
            hold_instr_reg  <= hold_instr_next;
            hold_odd_reg    <= hold_odd_next;
            hold_pc_reg     <= hold_pc_next;
        end
    end

    assign instr_even  = instr_even_reg;
    assign instr_odd   = instr_odd_reg;
    assign pc          = pc_reg;
    assign first_odd   = first_odd_reg;
    assign issue_valid = issue_valid_reg;

endmodule

// File: tb/tb_issue_pair_router.sv
// Directed bench for issue_pair_router: the stimulus process pushes expected
// issue groups into a queue; a monitor pops and compares whenever a new group
// appears on the outputs.
module tb_issue_pair_router;

    localparam logic [0:31] NE = 32'h40200000;
    localparam logic [0:31] NO = 32'h00200000;

    typedef struct {
        logic [0:31] ev;
        logic [0:31] od;
        logic [7:0]  pcv;
        logic        fo;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [0:31] instr_a = '0;
    logic [0:31] instr_b = '0;
    logic [7:0]  pc_a = '0;
    logic        odd_a = 1'b0;
    logic        odd_b = 1'b0;
    logic        wr_a = 1'b0;
    logic [0:6]  rt_a = '0;
    logic [0:6]  ra_b = '0;
    logic [0:6]  rb_b = '0;
    logic [0:6]  rc_b = '0;
    logic [2:0]  src_b_used = '0;
    logic        stall_even_raw = 1'b0;
    logic        stall_odd_raw = 1'b0;
    logic        branch_taken = 1'b0;
    logic [0:31] instr_even;
    logic [0:31] instr_odd;
    logic [7:0]  pc;
    logic        first_odd;
    logic        issue_valid;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    exp_t last_exp;
    logic was_stall = 1'b0;

    issue_pair_router dut (
        .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .instr_a(instr_a), .instr_b(instr_b), .pc_a(pc_a), .odd_a(odd_a), .odd_b(odd_b),
        .wr_a(wr_a), .rt_a(rt_a), .ra_b(ra_b), .rb_b(rb_b), .rc_b(rc_b),
        .src_b_used(src_b_used), .stall_even_raw(stall_even_raw),
        .stall_odd_raw(stall_odd_raw), .branch_taken(branch_taken),
        .instr_even(instr_even), .instr_odd(instr_odd), .pc(pc),
        .first_odd(first_odd), .issue_valid(issue_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_valid    = 1'b0;
        stall_even_raw = 1'b0;
        stall_odd_raw  = 1'b0;
        branch_taken   = 1'b0;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [7:0] p,
                         input logic oa, input logic ob, input logic wr, input logic [6:0] rt,
                         input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc,
                         input logic [2:0] used);
        fetch_valid = 1'b1;
        instr_a = a; instr_b = b; pc_a = p; odd_a = oa; odd_b = ob;
        wr_a = wr; rt_a = rt; ra_b = ra; rb_b = rb; rc_b = rc; src_b_used = used;
    endtask

    task automatic push(input logic [31:0] ev, input logic [31:0] od, input logic [7:0] p,
                        input logic fo);
        exp_t e;
        e.ev = ev; e.od = od; e.pcv = p; e.fo = fo;
        exp_q.push_back(e);
    endtask

    task automatic check_ready(input string name, input logic req);
        #1;
        check(name, {31'd0, fetch_ready}, {31'd0, req});
    endtask

    // Remember whether the edge just taken was a plain stall (outputs frozen).
    always @(posedge clk) begin
        was_stall <= (stall_even_raw | stall_odd_raw) & ~branch_taken & ~reset;
    end

    // Monitor: compare each newly presented issue group against the queue head.
    always @(negedge clk) begin
        if (was_stall) begin
            check("stall_hold_even", instr_even, last_exp.ev);
            check("stall_hold_odd", instr_odd, last_exp.od);
            check("stall_hold_pc", {24'd0, pc}, {24'd0, last_exp.pcv});
            check("stall_hold_valid", {31'd0, issue_valid}, 32'd1);
        end else if (issue_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_issue: got even=%h odd=%h pc=%h want no issue",
                         instr_even, instr_odd, pc);
            end else begin
                last_exp = exp_q.pop_front();
                check("issue_even", instr_even, last_exp.ev);
                check("issue_odd", instr_odd, last_exp.od);
                check("issue_pc", {24'd0, pc}, {24'd0, last_exp.pcv});
                check("issue_first_odd", {31'd0, first_odd}, {31'd0, last_exp.fo});
                $display("issue even=%h odd=%h pc=%h first_odd=%0d", instr_even, instr_odd,
                         pc, first_odd);
            end
        end else begin
            check("idle_nops", {instr_even, instr_odd}, {NE, NO});
        end
    end

    initial begin
        // Reset values.
        tick(); tick();
        check("rst_even", instr_even, NE);
        check("rst_odd", instr_odd, NO);
        check("rst_pc", {24'd0, pc}, 32'd0);
        check("rst_first_odd", {31'd0, first_odd}, 32'd0);
        check("rst_valid", {31'd0, issue_valid}, 32'd0);
        check_ready("rst_ready", 1'b0);
        reset = 1'b0;
        check_ready("ready_after_rst", 1'b1);

        // Pairable: even a writes r3, odd b does not read r3.
        drive(32'h18000000, 32'h34000000, 8'h10, 0, 1, 1, 7'd3, 7'd1, 7'd2, 7'd4, 3'b111);
        push(32'h18000000, 32'h34000000, 8'h10, 0);
        check_ready("pair_ready", 1'b1);
        tick(); idle();
        check_ready("pair_ready_after", 1'b1);
        tick();

        // Two evens: split over two cycles.
        drive(32'h18100000, 32'h18200000, 8'h20, 0, 0, 0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000);
        push(32'h18100000, NO, 8'h20, 0);
        push(32'h18200000, NO, 8'h21, 0);
        tick(); idle();
        check_ready("second_not_ready", 1'b0);
        tick();
        check_ready("ready_after_second", 1'b1);
        tick();

        // RAW on ra_b: split, b issues with first_odd=1.
        drive(32'h18300000, 32'h34100000, 8'h30, 0, 1, 1, 7'd5, 7'd5, 7'd0, 7'd0, 3'b100);
        push(32'h18300000, NO, 8'h30, 0);
        push(NE, 32'h34100000, 8'h31, 1);
        tick(); idle(); tick(); tick();

        // Matching rb_b but unused: still pairable.
        drive(32'h18400000, 32'h34200000, 8'h38, 0, 1, 1, 7'd5, 7'd0, 7'd5, 7'd0, 3'b100);
        push(32'h18400000, 32'h34200000, 8'h38, 0);
        tick(); idle(); tick();

        // Odd a, even b, RAW on rc_b: split with odd first.
        drive(32'h34300000, 32'h18500000, 8'h40, 1, 0, 1, 7'd9, 7'd0, 7'd0, 7'd9, 3'b001);
        push(NE, 32'h34300000, 8'h40, 1);
        push(32'h18500000, NO, 8'h41, 0);
        tick(); idle(); tick(); tick();

        // Two odds, then a 3-cycle odd RAW stall while in SECOND.
        drive(32'h34400000, 32'h34500000, 8'h50, 1, 1, 0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000);
        push(NE, 32'h34400000, 8'h50, 1);
        push(NE, 32'h34500000, 8'h51, 1);
        tick(); idle();
        stall_odd_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_ready("stall_not_ready", 1'b0);
            tick();
        end
        stall_odd_raw = 1'b0;
        tick(); tick();

        // Branch flush in SECOND, with stall and a pending fetch pair.
        drive(32'h18600000, 32'h18700000, 8'h60, 0, 0, 0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000);
        push(32'h18600000, NO, 8'h60, 0);
        tick();
        drive(32'h18800000, 32'h34600000, 8'h70, 0, 1, 0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000);
        branch_taken   = 1'b1;
        stall_even_raw = 1'b1;
        check_ready("flush_not_ready", 1'b0);
        tick(); idle();
        check("flush_valid", {31'd0, issue_valid}, 32'd0);
        check_ready("ready_after_flush", 1'b1);
        tick(); tick();

        // Split at pc 0xFF wraps to 0x00.
        drive(32'h18900000, 32'h18A00000, 8'hFF, 0, 0, 0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000);
        push(32'h18900000, NO, 8'hFF, 0);
        push(32'h18A00000, NO, 8'h00, 0);
        tick(); idle(); tick(); tick();

        // Reset in SECOND discards the held instruction.
        drive(32'h18B00000, 32'h18C00000, 8'h80, 0, 0, 0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000);
        push(32'h18B00000, NO, 8'h80, 0);
        tick(); idle();
        reset = 1'b1;
        tick();
        check("mid_rst_pc", {24'd0, pc}, 32'd0);
        check("mid_rst_first_odd", {31'd0, first_odd}, 32'd0);
        check("mid_rst_valid", {31'd0, issue_valid}, 32'd0);
        reset = 1'b0;
        check_ready("ready_after_mid_rst", 1'b1);
        tick(); tick(); tick();

        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issue_pair_router.md
Name: issue_pair_router

Overview:
- Issue stage directly upstream of the dual-issue execution block (register table, even/odd pipes, forwarding).
- Accepts a fetched instruction pair plus per-instruction classification from the decoder.
- Routes each instruction to the even or odd slot and splits pairs that cannot dual-issue (same pipe, or intra-pair RAW).
- Drives instr_even, instr_odd, pc and first_odd into the execution block; honours its RAW stall and branch flush.

Parameters:
- NOP_EVEN, 32'h40200000, even-pipe filler instruction (nop).
- NOP_ODD, 32'h00200000, odd-pipe filler instruction (lnop).
- PC_W, 8, program counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- fetch_valid  in  1  fetched pair valid.
- fetch_ready  out  1  pair accepted this cycle when fetch_valid && fetch_ready.
- instr_a  in  [0:31]  first (lower address) instruction.
- instr_b  in  [0:31]  second instruction.
- pc_a  in  [PC_W-1:0]  word pc of instr_a; instr_b is at pc_a+1.
- odd_a, odd_b  in  1 each  1 = odd pipe (perm/LS/branch), 0 = even pipe.
- wr_a  in  1  instr_a writes rt.
- rt_a  in  [0:6]  destination address of instr_a.
- ra_b, rb_b, rc_b  in  [0:6] each  source addresses of instr_b.
- src_b_used  in  [2:0]  bit2 = ra_b used, bit1 = rb_b used, bit0 = rc_b used.
- stall_even_raw, stall_odd_raw  in  1 each  RAW stall from the execution block.
- branch_taken  in  1  taken branch; flush.
- instr_even  out  [0:31]  even-slot instruction.
- instr_odd  out  [0:31]  odd-slot instruction.
- pc  out  [PC_W-1:0]  pc of the earliest instruction in the issued group.
- first_odd  out  1  odd-slot instruction is first in program order.
- issue_valid  out  1  at least one real instruction is issued.

Behaviour:
- stall = stall_even_raw | stall_odd_raw.
- Priority: reset > branch_taken > stall > normal.
- All outputs except fetch_ready are registered; latency is 1 cycle from acceptance to issue.
- Reset values: instr_even = NOP_EVEN, instr_odd = NOP_ODD, pc = 0, first_odd = 0, issue_valid = 0, state = RUN, hold registers cleared.
- fetch_ready (combinational) = !reset && state==RUN && !stall && !branch_taken.
- dep = wr_a && ((src_b_used[2] && ra_b==rt_a) || (src_b_used[1] && rb_b==rt_a) || (src_b_used[0] && rc_b==rt_a)).
- pairable = (odd_a != odd_b) && !dep.
- FSM has two states, RUN and SECOND.
- RUN, accept, pairable:
  - Each instruction goes to its pipe's slot.
  - pc <= pc_a, first_odd <= odd_a, issue_valid <= 1, stay RUN.
- RUN, accept, not pairable:
  - instr_a goes to its slot; the other slot gets its NOP.
  - pc <= pc_a, first_odd <= odd_a, issue_valid <= 1.
  - Latch instr_b, odd_b and pc_a+1 (mod 2^PC_W) into hold registers; go to SECOND.
- RUN, no accept (fetch_valid=0):
  - instr_even <= NOP_EVEN, instr_odd <= NOP_ODD, issue_valid <= 0, pc and first_odd hold.
- SECOND, !stall, !branch_taken:
  - Held instr_b goes to its slot; the other slot gets its NOP.
  - pc <= held pc, first_odd <= held odd_b, issue_valid <= 1, go to RUN.
  - fetch_ready is 0 in this cycle, so no new pair is accepted.
- stall in either state, no branch: every output register and the state hold; nothing accepted.
- branch_taken in any state:
  - Outputs become NOP_EVEN / NOP_ODD, issue_valid <= 0.
  - Any held instr_b is discarded; state <= RUN.
  - The fetch pair presented in that cycle is not accepted.
- branch_taken together with stall: the flush wins.
- Reset asserted mid-SECOND: the held instruction is discarded and all reset values apply on the next edge.

Test Plan:
- Accept a=0x18000000 (even, wr_a=1, rt=3), b=0x34000000 (odd, no use of r3), pc_a=0x10 -> next cycle: instr_even=a, instr_odd=b, pc=0x10, first_odd=0, issue_valid=1; fetch_ready stays 1.
- Two evens a, b at pc_a=0x20 -> cycle1: instr_even=a, instr_odd=NOP_ODD, pc=0x20, fetch_ready=0. Cycle2: instr_even=b, instr_odd=NOP_ODD, pc=0x21, fetch_ready=1.
- a even writes r5, b odd with ra_b=5, src_b_used=3'b100 -> split: a issues alone, then b alone with first_odd=1, pc=pc_a+1.
- Same-pipe split, then stall_odd_raw=1 for 3 cycles while in SECOND -> outputs frozen at a's issue, fetch_ready=0. b issues the cycle after the stall drops.
- branch_taken=1 while in SECOND with fetch_valid=1 -> next cycle both slots hold NOPs, issue_valid=0, b never issues, fetch pair not accepted, state RUN.
- Split pair at pc_a=8'hFF -> second issue has pc=8'h00; reset asserted in SECOND -> reset values next edge, no issue of b.
